// File: rtl/pwm_pkg.sv
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared types and signed saturation helper for the PWM datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

  typedef enum logic [1:0] {
    SHAPER_IDLE    = 2'd0,
    SHAPER_RUN     = 2'd1,
    SHAPER_TIMEOUT = 2'd2
  } shaper_state_t;

  // Symmetric clamp to [-limit, +limit]; callers size their operands to 32 bits.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input logic signed [31:0] limit);
    if (value > limit)
      return limit;
    else if (value < -limit)
      return -limit;
    else
      return value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_command_shaper_period_watchdog.sv
// ============================================================================
// Module   : period_watchdog
// Purpose  : Counts ticks since the last kick and flags expiry as a level.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module period_watchdog #(
  parameter int TIMEOUT_PERIODS = 100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic kick,
  output logic expired
);

  localparam int                 c_cnt_w = $clog2(TIMEOUT_PERIODS + 1);
  localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT_PERIODS);

  logic [c_cnt_w-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset_n)
      r_count <= '0;
    else if (kick)
      r_count <= '0;
    else if (tick && (r_count != c_limit))
      r_count <= r_count + 1'b1;
  end

  // Expiry is visible on the very tick that reaches the limit; a kick masks it.
  assign expired = !kick && ((r_count == c_limit) ||
                             (tick && (r_count == (c_limit - 1'b1))));

endmodule

`default_nettype wire

// File: rtl/pwm_command_shaper.sv
// ============================================================================
// Module   : pwm_command_shaper
// Purpose  : Clamps and slew-limits signed duty commands, one word per PWM period.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_command_shaper
  import pwm_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int MAX_MAGNITUDE   = 1000,
  parameter int MAX_STEP        = 64,
  parameter int TIMEOUT_PERIODS = 100
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         trigger,
  input  logic signed [DATA_WIDTH-1:0] cmd_data,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         clear_fault,
  output logic signed [DATA_WIDTH-1:0] pwm_source_data,
  output logic                         pwm_source_valid,
  output logic                         status_timeout,
  output logic                         status_active
);

  shaper_state_t                r_state;
  shaper_state_t                w_state_next;
  logic signed [DATA_WIDTH-1:0] r_target;
  logic signed [DATA_WIDTH-1:0] r_current;
  logic signed [DATA_WIDTH:0]   r_diff;
  logic                         r_pending;

  logic                         w_accept;
  logic                         w_expired;
  logic                         w_launch;
  logic signed [DATA_WIDTH-1:0] w_step;
  logic signed [DATA_WIDTH-1:0] w_cur_now;
  logic signed [DATA_WIDTH-1:0] w_goal;
  logic signed [DATA_WIDTH-1:0] w_cmd_clamped;
  logic signed [DATA_WIDTH:0]   w_diff;

  assign cmd_ready = reset_n && (r_state != SHAPER_TIMEOUT);
  assign w_accept  = cmd_valid && cmd_ready;

  period_watchdog #(
    .TIMEOUT_PERIODS (TIMEOUT_PERIODS)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (trigger),
    .kick    (w_accept),
    .expired (w_expired)
  );

  // The slew step registered last cycle lands now, so a back-to-back trigger sees it.
  assign w_step        = DATA_WIDTH'(sat_signed(32'(r_diff), MAX_STEP));
  assign w_cur_now     = r_pending ? (r_current + w_step) : r_current;
  assign w_cmd_clamped = DATA_WIDTH'(sat_signed(32'(cmd_data), MAX_MAGNITUDE));
  assign w_diff        = (DATA_WIDTH+1)'(w_goal) - (DATA_WIDTH+1)'(w_cur_now);

  always_comb begin
    w_state_next = r_state;
    w_goal       = r_target;
    w_launch     = 1'b0;
    case (r_state)
      SHAPER_IDLE: begin
        if (w_accept)
          w_state_next = SHAPER_RUN;
      end
      SHAPER_RUN: begin
        if (trigger) begin
          w_launch = 1'b1;
          if (w_expired) begin
            w_goal       = '0;
            w_state_next = SHAPER_TIMEOUT;
          end
        end
      end
      SHAPER_TIMEOUT: begin
        w_goal = '0;
        if (trigger && (w_cur_now != '0))
          w_launch = 1'b1;
        if (clear_fault && (w_cur_now == '0))
          w_state_next = SHAPER_IDLE;
      end
      default: w_state_next = SHAPER_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      r_state <= SHAPER_IDLE;
    else
      r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_target  <= '0;
      r_current <= '0;
      r_diff    <= '0;
      r_pending <= 1'b0;
    end else begin
      r_current <= w_cur_now;
      r_pending <= w_launch;
      if (w_launch)
        r_diff <= w_diff;
      if (w_accept)
        r_target <= w_cmd_clamped;
      else if (w_state_next == SHAPER_TIMEOUT)
        r_target <= '0;
    end
  end

  assign pwm_source_data  = w_cur_now;
  assign pwm_source_valid = r_pending;
  assign status_timeout   = (r_state == SHAPER_TIMEOUT);
  assign status_active    = (r_state == SHAPER_RUN);

endmodule

`default_nettype wire

// File: tb/tb_pwm_command_shaper.sv
// ============================================================================
// Module   : tb_pwm_command_shaper
// Purpose  : Random stimulus against a period-level reference model of the shaper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_command_shaper;

  localparam int c_dw    = 16;
  localparam int c_mag   = 1000;
  localparam int c_step  = 64;
  localparam int c_tmo   = 4;
  localparam int c_cycles = 6000;

  localparam int c_m_idle = 0;
  localparam int c_m_run  = 1;
  localparam int c_m_tmo  = 2;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   trigger;
  logic signed [c_dw-1:0] cmd_data;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   clear_fault;
  logic signed [c_dw-1:0] pwm_source_data;
  logic                   pwm_source_valid;
  logic                   status_timeout;
  logic                   status_active;

  int n_compared   = 0;
  int n_mismatched = 0;

  int m_st, m_tgt, m_cur, m_wd, m_valid;

  pwm_command_shaper #(
    .DATA_WIDTH      (c_dw),
    .MAX_MAGNITUDE   (c_mag),
    .MAX_STEP        (c_step),
    .TIMEOUT_PERIODS (c_tmo)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .trigger          (trigger),
    .cmd_data         (cmd_data),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .clear_fault      (clear_fault),
    .pwm_source_data  (pwm_source_data),
    .pwm_source_valid (pwm_source_valid),
    .status_timeout   (status_timeout),
    .status_active    (status_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lim);
    if (v > lim)  return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  // Period-level model: each trigger moves the duty immediately and the
  // resulting word is what the block must present for the following clock.
  task automatic model_step();
    int st0, cur0, acc, goal;
    if (!reset_n) begin
      m_st = c_m_idle; m_tgt = 0; m_cur = 0; m_wd = 0; m_valid = 0;
      return;
    end
    st0     = m_st;
    cur0    = m_cur;
    acc     = (cmd_valid && st0 != c_m_tmo) ? 1 : 0;
    m_valid = 0;
    if (trigger) begin
      if (st0 == c_m_run) begin
        goal = m_tgt;
        if (!acc && (m_wd + 1 >= c_tmo)) begin
          goal  = 0;
          m_st  = c_m_tmo;
          m_tgt = 0;
        end
        m_cur   = m_cur + clampi(goal - m_cur, c_step);
        m_valid = 1;
      end else if (st0 == c_m_tmo && m_cur != 0) begin
        m_cur   = m_cur + clampi(-m_cur, c_step);
        m_valid = 1;
      end
    end
    if (acc)
      m_wd = 0;
    else if (trigger && m_wd < c_tmo)
      m_wd++;
    if (acc) begin
      m_tgt = clampi(int'(cmd_data), c_mag);
      if (st0 == c_m_idle) m_st = c_m_run;
    end
    if (st0 == c_m_tmo && clear_fault && cur0 == 0)
      m_st = c_m_idle;
  endtask

  task automatic check_outputs();
    check("valid",   int'(pwm_source_valid), m_valid);
    check("data",    int'(pwm_source_data),  m_cur);
    check("timeout", int'(status_timeout),   (m_st == c_m_tmo) ? 1 : 0);
    check("active",  int'(status_active),    (m_st == c_m_run) ? 1 : 0);
    check("ready",   int'(cmd_ready),        (reset_n && m_st != c_m_tmo) ? 1 : 0);
  endtask

  task automatic pick_cmd();
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0:       cmd_data = 16'sh8000;
      1:       cmd_data = 16'sh7fff;
      2, 3, 4: cmd_data = c_dw'($urandom_range(0, 2400) - 1200);
      5:       cmd_data = c_dw'($urandom_range(0, 200) - 100);
      default: cmd_data = c_dw'($urandom);
    endcase
  endtask

  initial begin
    int gap;
    int cmd_pct;
    reset_n     = 1'b0;
    trigger     = 1'b0;
    cmd_data    = '0;
    cmd_valid   = 1'b0;
    clear_fault = 1'b0;
    m_st = c_m_idle; m_tgt = 0; m_cur = 0; m_wd = 0; m_valid = 0;
    gap  = 0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      model_step();
      #1;
      check_outputs();
    end
    reset_n = 1'b1;

    for (int cyc = 0; cyc < c_cycles; cyc++) begin
      @(posedge clk);
      model_step();
      #1;
      check_outputs();

      // Rotate between busy, sparse and silent host phases to reach timeouts.
      case ((cyc / 250) % 3)
        0:       cmd_pct = 40;
        1:       cmd_pct = 5;
        default: cmd_pct = 0;
      endcase
      if (gap == 0) begin
        trigger = 1'b1;
        gap     = $urandom_range(0, 4);
      end else begin
        trigger = 1'b0;
        gap--;
      end
      cmd_valid = ($urandom_range(0, 99) < cmd_pct);
      pick_cmd();
      clear_fault = ($urandom_range(0, 9) == 0);
      reset_n     = ($urandom_range(0, 399) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

`default_nettype wire
